bsg_arb_rr_locked: RTL and testbench

Round-robin arbiter that shares one downstream channel among `width_p` requesters. It holds the grant across multi-beat packets until the packet ends or a beat limit is reached. The requester choice is a lo-to-hi priority encode of the request vector, rotated to start one position past the last winner. The block sits between the requester FIFOs and the shared channel, and it is the sequencing controller for the priority-encode datapath.

---
 rtl/bsg_arb_rr_locked_pkg.sv | 17 +
 rtl/bsg_priority_encode.sv | 28 ++
 rtl/bsg_arb_rr_locked.sv | 110 +++++++++++
 tb/tb_bsg_arb_rr_locked.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bsg_arb_rr_locked_pkg.sv
// Shared types and helpers for the locked round-robin arbiter.
// The state encoding and the index rotation are used by the arbiter top.
package bsg_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } bsg_arb_state_e;

  // Modular index rotation; width must be a power of two so the mask is the modulus.
  function automatic int unsigned bsg_arb_rotate(input int unsigned idx,
                                                 input int unsigned amount,
                                                 input int unsigned width);
    return (idx + amount) & (width - 1);
  endfunction

endpackage

// File: rtl/bsg_priority_encode.sv
// Priority encoder over a request vector: returns the index of the first set bit
// scanning from bit 0 upward (lo_to_hi_p=1) or from the top downward (lo_to_hi_p=0).
module bsg_priority_encode #(
  parameter int width_p    = 16,
  parameter int lo_to_hi_p = 1,
  parameter int lg_width_p = $clog2(width_p)
) (
  input  logic [width_p-1:0]    i,
  output logic [lg_width_p-1:0] addr_o,
  output logic                  v_o
);

  // The last matching bit visited in each loop wins, so the scan runs away from the priority end.
  always_comb begin
    addr_o = '0;
    v_o    = |i;
    if (lo_to_hi_p != 0) begin
      for (int k = width_p - 1; k >= 0; k--) begin
        if (i[k]) addr_o = lg_width_p'(k);
      end
    end else begin
      for (int k = 0; k < width_p; k++) begin
        if (i[k]) addr_o = lg_width_p'(k);
      end
    end
  end

endmodule

// File: rtl/bsg_arb_rr_locked.sv
// Round-robin arbiter that keeps its grant on one requester for a whole multi-beat
// packet, releasing on the packet's last beat or after max_beats_p beats.
module bsg_arb_rr_locked
  import bsg_arb_pkg::*;
#(
  parameter int width_p     = 16,
  parameter int lg_width_p  = $clog2(width_p),
  parameter int max_beats_p = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [width_p-1:0]    reqs_i,
  input  logic                  last_i,
  input  logic                  yumi_i,
  output logic [width_p-1:0]    grants_o,
  output logic [lg_width_p-1:0] tag_o,
  output logic                  v_o,
  output logic                  locked_o
);

  localparam int beats_w_lp = (max_beats_p > 1) ? $clog2(max_beats_p) : 1;

  bsg_arb_state_e        state_r;
  logic [lg_width_p-1:0] last_r;
  logic [lg_width_p-1:0] owner_r;
  logic [beats_w_lp-1:0] beats_r;

  logic [lg_width_p-1:0] rot_amount;
  logic [width_p-1:0]    reqs_rot;
  logic [lg_width_p-1:0] enc_addr;
  logic                  enc_v;
  logic [lg_width_p-1:0] winner;
  logic [lg_width_p-1:0] sel_tag;
  logic [lg_width_p-1:0] src_idx;

  // Start the search one past the last winner; the narrow add wraps naturally.
  assign rot_amount = last_r + 1'b1;

  always_comb begin
    reqs_rot = '0;
    src_idx  = '0;
    for (int k = 0; k < width_p; k++) begin
      src_idx     = lg_width_p'(bsg_arb_rotate(k, 32'(rot_amount), width_p));
      reqs_rot[k] = reqs_i[src_idx];
    end
  end

  bsg_priority_encode #(
    .width_p    (width_p),
    .lo_to_hi_p (1),
    .lg_width_p (lg_width_p)
  ) encoder (
    .i      (reqs_rot),
    .addr_o (enc_addr),
    .v_o    (enc_v)
  );

  assign winner = lg_width_p'(bsg_arb_rotate(32'(enc_addr), 32'(rot_amount), width_p));

  // While locked, only the owner's request matters, even if it drops and others wait.
  always_comb begin
    v_o     = 1'b0;
    sel_tag = '0;
    if (state_r == LOCKED) begin
      v_o     = reqs_i[owner_r];
      sel_tag = owner_r;
    end else begin
      v_o     = enc_v;
      sel_tag = winner;
    end
    tag_o    = v_o ? sel_tag : '0;
    grants_o = v_o ? (width_p'(1) << sel_tag) : '0;
  end

  assign locked_o = (state_r == LOCKED);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      last_r  <= '1;
      owner_r <= '0;
      beats_r <= '0;
    end else if (yumi_i && v_o) begin
      case (state_r)
        IDLE: begin
          last_r <= winner;
          if (last_i || (max_beats_p == 1)) begin
            beats_r <= '0;
          end else begin
            state_r <= LOCKED;
            owner_r <= winner;
            beats_r <= beats_w_lp'(1);
          end
        end
        LOCKED: begin
          if (last_i || (beats_r == beats_w_lp'(max_beats_p - 1))) begin
            state_r <= IDLE;
            beats_r <= '0;
          end else begin
            beats_r <= beats_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_arb_rr_locked.sv
// Directed bench for bsg_arb_rr_locked: a vector table for fairness, lock hold and
// wrap-around, plus hand-written sequences for forced release, owner stall and reset.
module tb_bsg_arb_rr_locked;

  logic        clk_i;
  logic        reset_i;
  logic [15:0] reqs_i;
  logic        last_i;
  logic        yumi_i;
  logic [15:0] grants_o;
  logic [3:0]  tag_o;
  logic        v_o;
  logic        locked_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] reqs;
    logic        last;
    logic        yumi;
    logic        exp_v;
    logic [3:0]  exp_tag;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[$];

  bsg_arb_rr_locked #(
    .width_p     (16),
    .lg_width_p  (4),
    .max_beats_p (8)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (reqs_i),
    .last_i   (last_i),
    .yumi_i   (yumi_i),
    .grants_o (grants_o),
    .tag_o    (tag_o),
    .v_o      (v_o),
    .locked_o (locked_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change on the falling edge so they are stable well before the next rising edge.
  task automatic applyStimulus(input logic [15:0] reqs, input logic last, input logic yumi,
                               input logic rst);
    @(negedge clk_i);
    reqs_i  = reqs;
    last_i  = last;
    yumi_i  = yumi;
    reset_i = rst;
  endtask

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic exp_v, input logic [3:0] exp_tag,
                             input logic exp_locked);
    logic [15:0] exp_grants;
    exp_grants = exp_v ? (16'h1 << exp_tag) : 16'h0;
    #1;
    checkVal({name, ".v"}, 32'(v_o), 32'(exp_v));
    checkVal({name, ".tag"}, 32'(tag_o), 32'(exp_v ? exp_tag : 4'd0));
    checkVal({name, ".grants"}, 32'(grants_o), 32'(exp_grants));
    checkVal({name, ".locked"}, 32'(locked_o), 32'(exp_locked));
  endtask

  task automatic addVec(input logic [15:0] reqs, input logic last, input logic yumi,
                        input logic exp_v, input logic [3:0] exp_tag, input logic exp_locked);
    vec_t v;
    v.reqs = reqs; v.last = last; v.yumi = yumi;
    v.exp_v = exp_v; v.exp_tag = exp_tag; v.exp_locked = exp_locked;
    vecs.push_back(v);
  endtask

  initial begin
    reset_i = 1'b1;
    reqs_i  = '0;
    last_i  = 1'b0;
    yumi_i  = 1'b0;

    // Fairness: every requester busy, single-beat packets, tag walks 0..15 then back to 0.
    for (int k = 0; k < 17; k++) addVec(16'hFFFF, 1'b1, 1'b1, 1'b1, 4'(k % 16), 1'b0);
    // Lock hold: requester 1 sends four beats, then requester 2 is next.
    addVec(16'h0006, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    addVec(16'h0006, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1);
    addVec(16'h0006, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1);
    addVec(16'h0006, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1);
    addVec(16'h0006, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    addVec(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    // Wrap-around: 15 wins, then 0 has top priority, then 15 again.
    addVec(16'h8000, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
    addVec(16'h8001, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    addVec(16'h8001, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0);

    repeat (2) @(posedge clk_i);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset", 1'b0, 4'd0, 1'b0);
    checkVal("reset.beats", 32'(dut.beats_r), 32'd0);

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].reqs, vecs[n].last, vecs[n].yumi, 1'b0);
      checkOutput($sformatf("vec%0d", n), vecs[n].exp_v, vecs[n].exp_tag, vecs[n].exp_locked);
    end

    // Forced release: requester 5 alone, never signals last, lock drops after 8 beats.
    for (int b = 0; b < 8; b++) begin
      applyStimulus(16'h0020, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("force.beat%0d", b + 1), 1'b1, 4'd5, b > 0);
    end
    applyStimulus(16'h0021, 1'b1, 1'b1, 1'b0);
    checkOutput("force.release", 1'b1, 4'd0, 1'b0);
    checkVal("force.beats", 32'(dut.beats_r), 32'd0);

    // Owner stall: locked on 3, owner drops while 8 requests, owner returns.
    applyStimulus(16'h0008, 1'b0, 1'b1, 1'b0);
    checkOutput("stall.win", 1'b1, 4'd3, 1'b0);
    applyStimulus(16'h0100, 1'b0, 1'b0, 1'b0);
    checkOutput("stall.gap", 1'b0, 4'd0, 1'b1);
    applyStimulus(16'h0008, 1'b1, 1'b1, 1'b0);
    checkOutput("stall.back", 1'b1, 4'd3, 1'b1);

    // Reset mid-packet: requester 7 locks, reset lands on beat 2.
    applyStimulus(16'h0080, 1'b0, 1'b1, 1'b0);
    checkOutput("rst.beat1", 1'b1, 4'd7, 1'b0);
    applyStimulus(16'h0080, 1'b0, 1'b1, 1'b1);
    checkOutput("rst.beat2", 1'b1, 4'd7, 1'b1);
    applyStimulus(16'h0081, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.after", 1'b1, 4'd0, 1'b0);
    checkVal("rst.beats", 32'(dut.beats_r), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
